// File: rtl/cordic_share_arbiter_if.sv
// cordic_share_arbiter_if: client and CORDIC-side signals of the shared CORDIC arbiter
// slave  : arbiter view (takes requests and CORDIC results, drives grants and CORDIC inputs)
// master : client/CORDIC view (drives requests, client operands and CORDIC results)
interface cordic_share_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req, rel, gnt;
    logic [NUM_REQ-1:0]            cli_vec_en, cli_rot_en, cli_rot_micro;
    logic [NUM_REQ*DATA_WIDTH-1:0] cli_vec_xin, cli_vec_yin, cli_rot_xin, cli_rot_yin;
    logic [2*NUM_REQ-1:0]          cli_rot_quad;
    logic [NUM_REQ-1:0]            cli_vec_opvld, cli_rot_opvld;
    logic [DATA_WIDTH-1:0]         vec_xout, rot_xout, rot_yout;
    logic [ANGLE_WIDTH-1:0]        vec_angle;
    logic [1:0]                    vec_quad;
    logic                          cordic_vec_en, cordic_rot_en;
    logic [DATA_WIDTH-1:0]         cordic_vec_xin, cordic_vec_yin, cordic_rot_xin, cordic_rot_yin;
    logic [1:0]                    cordic_rot_quad_in;
    logic                          cordic_rot_angle_microRot_n;
    logic                          cordic_nrst;
    logic                          cordic_vec_opvld, cordic_rot_opvld;
    logic [DATA_WIDTH-1:0]         cordic_vec_xout, cordic_rot_xout, cordic_rot_yout;
    logic [ANGLE_WIDTH-1:0]        vec_angle_out;
    logic [1:0]                    vec_quad_in;
    logic                          busy;
    logic [2:0]                    owner_id;
    logic                          timeout_err;

    modport slave (
        input  req, rel, cli_vec_en, cli_rot_en, cli_rot_micro,
        input  cli_vec_xin, cli_vec_yin, cli_rot_xin, cli_rot_yin, cli_rot_quad,
        input  cordic_vec_opvld, cordic_rot_opvld, cordic_vec_xout, cordic_rot_xout,
        input  cordic_rot_yout, vec_angle_out, vec_quad_in,
        output gnt, cli_vec_opvld, cli_rot_opvld, vec_xout, vec_angle, vec_quad,
        output rot_xout, rot_yout, cordic_vec_en, cordic_rot_en,
        output cordic_vec_xin, cordic_vec_yin, cordic_rot_xin, cordic_rot_yin,
        output cordic_rot_quad_in, cordic_rot_angle_microRot_n, cordic_nrst,
        output busy, owner_id, timeout_err
    );

    modport master (
        output req, rel, cli_vec_en, cli_rot_en, cli_rot_micro,
        output cli_vec_xin, cli_vec_yin, cli_rot_xin, cli_rot_yin, cli_rot_quad,
        output cordic_vec_opvld, cordic_rot_opvld, cordic_vec_xout, cordic_rot_xout,
        output cordic_rot_yout, vec_angle_out, vec_quad_in,
        input  gnt, cli_vec_opvld, cli_rot_opvld, vec_xout, vec_angle, vec_quad,
        input  rot_xout, rot_yout, cordic_vec_en, cordic_rot_en,
        input  cordic_vec_xin, cordic_vec_yin, cordic_rot_xin, cordic_rot_yin,
        input  cordic_rot_quad_in, cordic_rot_angle_microRot_n, cordic_nrst,
        input  busy, owner_id, timeout_err
    );
endinterface

// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter: round-robin locked-grant sharing of one vectoring and one rotation CORDIC
// clk, rst : clock and asynchronous active-high reset
// bus      : slave side of cordic_share_arbiter_if (client requests/operands, grants,
//            CORDIC operand mux, CORDIC reset, gated valids, broadcast results, status)
module cordic_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int ANGLE_WIDTH  = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input logic                   clk,
    input logic                   rst,
    cordic_share_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, GRANT, OWNED} state_t;

    state_t             state;
    logic [IW-1:0]      own, rr, pick, own_nxt;
    logic [FW-1:0]      fcnt;
    logic [WW-1:0]      wd;
    logic [NUM_REQ-1:0] req_rot;
    logic [1:0]         en_now, en_q;
    logic               owned, act, rel_own, wd_exp;

    // Rotate requests so bit k is client rr+k; the lowest set bit wins.
    always_comb begin
        req_rot = NUM_REQ'({bus.req, bus.req} >> rr);
        pick = rr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_rot[k]) pick = IW'((int'(rr) + k) % NUM_REQ);
    end

    assign owned   = (state == OWNED);
    assign own_nxt = (own == IW'(NUM_REQ - 1)) ? '0 : own + 1'b1;

    assign bus.cordic_vec_en  = owned ? bus.cli_vec_en[own] : 1'b0;
    assign bus.cordic_rot_en  = owned ? bus.cli_rot_en[own] : 1'b0;
    assign bus.cordic_vec_xin = owned ? bus.cli_vec_xin[own*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.cordic_vec_yin = owned ? bus.cli_vec_yin[own*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.cordic_rot_xin = owned ? bus.cli_rot_xin[own*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.cordic_rot_yin = owned ? bus.cli_rot_yin[own*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.cordic_rot_quad_in = owned ? bus.cli_rot_quad[own*2 +: 2] : '0;
    assign bus.cordic_rot_angle_microRot_n = owned ? bus.cli_rot_micro[own] : 1'b0;

    assign bus.cli_vec_opvld = bus.gnt & {NUM_REQ{bus.cordic_vec_opvld}};
    assign bus.cli_rot_opvld = bus.gnt & {NUM_REQ{bus.cordic_rot_opvld}};
    assign bus.vec_xout  = bus.cordic_vec_xout;
    assign bus.vec_angle = ANGLE_WIDTH'(bus.vec_angle_out);
    assign bus.vec_quad  = bus.vec_quad_in;
    assign bus.rot_xout  = bus.cordic_rot_xout;
    assign bus.rot_yout  = bus.cordic_rot_yout;
    assign bus.owner_id  = 3'(own);

    // Watchdog activity: any CORDIC valid or a fresh owner enable.
    assign en_now  = {bus.cordic_vec_en, bus.cordic_rot_en};
    assign act     = bus.cordic_vec_opvld | bus.cordic_rot_opvld | (|(en_now & ~en_q));
    assign rel_own = bus.rel[own] | ~bus.req[own];
    assign wd_exp  = (wd == WW'(TIMEOUT - 1)) & ~act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            own             <= '0;
            rr              <= '0;
            fcnt            <= '0;
            wd              <= '0;
            en_q            <= '0;
            bus.gnt         <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.cordic_nrst <= 1'b0;
        end else begin
            en_q            <= en_now;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE:
                    if (|bus.req) begin
                        own   <= pick;
                        fcnt  <= '0;
                        state <= FLUSH;
                    end
                FLUSH:
                    if (!bus.req[own]) begin
                        own   <= '0;
                        state <= IDLE;
                    end else if (fcnt == FW'(FLUSH_CYCLES - 1)) begin
                        bus.cordic_nrst <= 1'b1;
                        state           <= GRANT;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                GRANT: begin
                    bus.gnt  <= NUM_REQ'(1) << own;
                    bus.busy <= 1'b1;
                    wd       <= '0;
                    state    <= OWNED;
                end
                OWNED:
                    // A real release takes precedence, so a coincident timeout raises no error.
                    if (rel_own || wd_exp) begin
                        bus.gnt         <= '0;
                        bus.busy        <= 1'b0;
                        bus.cordic_nrst <= 1'b0;
                        bus.timeout_err <= !rel_own;
                        rr              <= own_nxt;
                        own             <= '0;
                        wd              <= '0;
                        state           <= IDLE;
                    end else begin
                        wd <= act ? '0 : wd + 1'b1;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_share_arbiter.sv
// tb_cordic_share_arbiter: directed self-checking bench for cordic_share_arbiter
module tb_cordic_share_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int FL = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc;

    always #5 clk = ~clk;

    cordic_share_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) bif ();

    cordic_share_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .FLUSH_CYCLES(FL), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.req = '0; bif.rel = '0;
        bif.cli_vec_en = '0; bif.cli_rot_en = '0; bif.cli_rot_micro = '0;
        bif.cli_vec_xin = '0; bif.cli_vec_yin = '0; bif.cli_rot_xin = '0; bif.cli_rot_yin = '0;
        bif.cli_rot_quad = '0;
        bif.cordic_vec_opvld = 1'b0; bif.cordic_rot_opvld = 1'b0;
        bif.cordic_vec_xout = '0; bif.cordic_rot_xout = '0; bif.cordic_rot_yout = '0;
        bif.vec_angle_out = '0; bif.vec_quad_in = '0;
    endtask

    task automatic wait_gnt(output int c);
        bit bad;
        bad = 1'b0;
        c = 0;
        while (bif.gnt == '0 && c < 40) begin
            step(1);
            c++;
            if (bif.gnt != '0 && !bif.cordic_nrst) bad = 1'b1;
        end
        chk("gnt_rises", 32'(bif.gnt != '0), 1);
        chk("gnt_while_flush", 32'(bad), 0);
    endtask

    task automatic owner_rot(input int i);
        bif.cli_rot_en[i] = 1'b1;
        #1;
        chk("rot_en_mux", 32'(bif.cordic_rot_en), 1);
        step(1);
        bif.cli_rot_en[i] = 1'b0;
        bif.cordic_rot_opvld = 1'b1;
        #1;
        chk("rot_opvld_gate", 32'(bif.cli_rot_opvld), 32'(1) << i);
        step(1);
        bif.cordic_rot_opvld = 1'b0;
        bif.rel[i] = 1'b1;
        step(1);
        bif.rel[i] = 1'b0;
        chk("rel_gnt", 32'(bif.gnt), 0);
        chk("rel_nrst", 32'(bif.cordic_nrst), 0);
        chk("rel_busy", 32'(bif.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(bif.gnt), 0);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_owner", 32'(bif.owner_id), 0);
        chk("rst_terr", 32'(bif.timeout_err), 0);
        chk("rst_nrst", 32'(bif.cordic_nrst), 0);
        chk("rst_vec_en", 32'(bif.cordic_vec_en), 0);
        chk("rst_rot_en", 32'(bif.cordic_rot_en), 0);
        step(2);
        rst = 1'b0;

        // round robin with all clients requesting
        bif.req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(cyc);
            chk("rr_gap", 32'(cyc), 2 + FL);
            chk("rr_gnt", 32'(bif.gnt), 32'(1) << (k % N));
            chk("rr_owner", 32'(bif.owner_id), k % N);
            owner_rot(k % N);
        end

        // non-owner release is ignored, owner drops req to release
        bif.req = 4'b1010;
        wait_gnt(cyc);
        chk("nonown_gnt", 32'(bif.gnt), 4'b0010);
        bif.rel[3] = 1'b1;
        step(1);
        bif.rel[3] = 1'b0;
        chk("nonown_rel_gnt", 32'(bif.gnt), 4'b0010);
        chk("nonown_rel_busy", 32'(bif.busy), 1);
        step(2);
        chk("nonown_hold", 32'(bif.gnt), 4'b0010);
        bif.req[1] = 1'b0;
        step(1);
        chk("reqdrop_gnt", 32'(bif.gnt), 0);
        chk("reqdrop_owner", 32'(bif.owner_id), 0);
        wait_gnt(cyc);
        chk("next_owner3", 32'(bif.gnt), 4'b1000);
        bif.req = '0;
        step(1);
        chk("rel3_gnt", 32'(bif.gnt), 0);

        // watchdog forced release
        bif.req = 4'b0011;
        wait_gnt(cyc);
        chk("wd_owner0", 32'(bif.gnt), 4'b0001);
        step(TO - 1);
        chk("wd_hold", 32'(bif.gnt), 4'b0001);
        chk("wd_err_early", 32'(bif.timeout_err), 0);
        step(1);
        chk("wd_release", 32'(bif.gnt), 0);
        chk("wd_err", 32'(bif.timeout_err), 1);
        step(1);
        chk("wd_err_pulse", 32'(bif.timeout_err), 0);
        wait_gnt(cyc);
        chk("wd_next_owner1", 32'(bif.gnt), 4'b0010);

        // release coinciding with timeout is a normal release
        step(TO - 1);
        bif.rel[1] = 1'b1;
        step(1);
        bif.rel[1] = 1'b0;
        chk("sim_release", 32'(bif.gnt), 0);
        chk("sim_no_err", 32'(bif.timeout_err), 0);

        // operand mux isolation
        bif.cli_vec_xin[0 +: DW] = 16'h1234;
        bif.cli_vec_en[1] = 1'b1;
        bif.cli_vec_xin[DW +: DW] = 16'h7FFF;
        #1;
        chk("pre_vec_en", 32'(bif.cordic_vec_en), 0);
        chk("pre_vec_xin", 32'(bif.cordic_vec_xin), 0);
        wait_gnt(cyc);
        chk("mux_owner0", 32'(bif.gnt), 4'b0001);
        chk("mux_xin", 32'(bif.cordic_vec_xin), 16'h1234);
        chk("mux_en", 32'(bif.cordic_vec_en), 0);
        bif.cordic_vec_opvld = 1'b1;
        bif.cordic_vec_xout = 16'h0005;
        bif.vec_angle_out = 16'h2345;
        bif.vec_quad_in = 2'd2;
        #1;
        chk("vec_opvld_gate", 32'(bif.cli_vec_opvld), 4'b0001);
        chk("bcast_xout", 32'(bif.vec_xout), 16'h0005);
        chk("bcast_angle", 32'(bif.vec_angle), 16'h2345);
        chk("bcast_quad", 32'(bif.vec_quad), 2);
        bif.cordic_vec_opvld = 1'b0;
        bif.req = '0;
        step(1);
        chk("mux_rel_gnt", 32'(bif.gnt), 0);
        chk("idle_vec_en", 32'(bif.cordic_vec_en), 0);
        chk("idle_vec_xin", 32'(bif.cordic_vec_xin), 0);
        chk("idle_bcast", 32'(bif.vec_xout), 16'h0005);
        clear_inputs();

        // single client vec (3,4) then rot (4,3), then async reset mid-OWNED
        bif.req = 4'b0100;
        wait_gnt(cyc);
        chk("single_gnt", 32'(bif.gnt), 4'b0100);
        bif.cli_vec_en[2] = 1'b1;
        bif.cli_vec_xin[2*DW +: DW] = 16'd3;
        bif.cli_vec_yin[2*DW +: DW] = 16'd4;
        bif.cli_rot_en[2] = 1'b1;
        bif.cli_rot_xin[2*DW +: DW] = 16'd4;
        bif.cli_rot_yin[2*DW +: DW] = 16'd3;
        bif.cli_rot_quad[4 +: 2] = 2'b01;
        bif.cli_rot_micro[2] = 1'b1;
        bif.cordic_rot_opvld = 1'b1;
        #1;
        chk("single_vec_en", 32'(bif.cordic_vec_en), 1);
        chk("single_vec_xin", 32'(bif.cordic_vec_xin), 3);
        chk("single_vec_yin", 32'(bif.cordic_vec_yin), 4);
        chk("single_rot_xin", 32'(bif.cordic_rot_xin), 4);
        chk("single_rot_yin", 32'(bif.cordic_rot_yin), 3);
        chk("single_rot_quad", 32'(bif.cordic_rot_quad_in), 1);
        chk("single_rot_micro", 32'(bif.cordic_rot_angle_microRot_n), 1);
        chk("single_rot_opvld", 32'(bif.cli_rot_opvld), 4'b0100);
        #1 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(bif.gnt), 0);
        chk("arst_nrst", 32'(bif.cordic_nrst), 0);
        chk("arst_busy", 32'(bif.busy), 0);
        chk("arst_vec_en", 32'(bif.cordic_vec_en), 0);
        chk("arst_owner", 32'(bif.owner_id), 0);
        clear_inputs();
        bif.req = 4'hF;
        step(1);
        rst = 1'b0;
        wait_gnt(cyc);
        chk("restart_0", 32'(bif.gnt), 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cordic_share_arbiter.md
Name: cordic_share_arbiter

Overview:
- Shares one vectoring CORDIC and one rotation CORDIC between NUM_REQ clients, such as dot-product, norm and Givens engines in the FastICA estimator.
- Uses round-robin arbitration with a locked grant: the owner keeps both CORDICs across its full vec-then-rot sequence until it releases them.
- Flushes the CORDICs (cordic_nrst low) on every change of ownership.
- A watchdog reclaims the CORDICs from a stalled owner.

Parameters:
NUM_REQ, 4, number of clients (2..8)
DATA_WIDTH, 16, CORDIC data width
ANGLE_WIDTH, 16, CORDIC angle width
FLUSH_CYCLES, 2, cycles cordic_nrst is held low before each grant (>=1)
TIMEOUT, 1024, idle cycles with no owner activity before forced release

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-client request, level
rel  in  NUM_REQ  per-client release pulse
gnt  out  NUM_REQ  one-hot grant
cli_vec_en  in  NUM_REQ  client vectoring enable
cli_vec_xin, cli_vec_yin  in  NUM_REQ*DATA_WIDTH  packed, client i at [i*DATA_WIDTH +: DATA_WIDTH]
cli_rot_en  in  NUM_REQ  client rotation enable
cli_rot_xin, cli_rot_yin  in  NUM_REQ*DATA_WIDTH  packed as above
cli_rot_quad  in  2*NUM_REQ  packed quadrant
cli_rot_micro  in  NUM_REQ  angle/microRot select
cli_vec_opvld, cli_rot_opvld  out  NUM_REQ  valids, gated to owner
vec_xout  out  DATA_WIDTH  broadcast
vec_angle  out  ANGLE_WIDTH  broadcast
vec_quad  out  2  broadcast
rot_xout, rot_yout  out  DATA_WIDTH  broadcast
cordic_vec_en, cordic_rot_en  out  1  to CORDICs
cordic_vec_xin, cordic_vec_yin, cordic_rot_xin, cordic_rot_yin  out  DATA_WIDTH  to CORDICs
cordic_rot_quad_in  out  2  to rotation CORDIC
cordic_rot_angle_microRot_n  out  1  to rotation CORDIC
cordic_nrst  out  1  CORDIC reset, active-low
cordic_vec_opvld, cordic_rot_opvld  in  1  from CORDICs
cordic_vec_xout, vec_angle_out, cordic_rot_xout, cordic_rot_yout  in  widths above  from CORDICs
vec_quad_in  in  2  from vectoring CORDIC
busy  out  1  an owner holds the CORDICs
owner_id  out  3  index of current owner (0 when idle)
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=0, busy=0, owner_id=0, timeout_err=0.
  - cordic_nrst=0; all CORDIC enables and data outputs 0; rr pointer=0; watchdog=0.
- States: IDLE, FLUSH, GRANT, OWNED.
- IDLE:
  - cordic_nrst=0.
  - If any req bit is set, pick the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Register the pick in owner_id and go to FLUSH.
- FLUSH:
  - cordic_nrst=0 for FLUSH_CYCLES cycles, counted by an internal counter, then go to GRANT.
  - If req[owner] drops during FLUSH, return to IDLE without granting.
- GRANT: cordic_nrst=1; gnt[owner_id]=1 and busy=1 registered at the end of this cycle; go to OWNED.
- OWNED:
  - gnt stays one-hot.
  - CORDIC inputs are a combinational mux of the owner's cli_* signals; outside OWNED, enables and data are forced to 0.
  - cli_*_opvld[i] = cordic_*_opvld & gnt[i], so non-owners never see valid.
  - Result buses are broadcast unconditionally.
- Release:
  - Triggers: rel[owner_id]=1, or req[owner_id]=0, in OWNED.
  - Next cycle: gnt=0, busy=0, cordic_nrst=0, state=IDLE, rr pointer=owner_id+1 mod NUM_REQ.
  - rel from a non-owner is ignored.
  - A client that releases and re-requests waits its round-robin turn.
- Back-to-back handoff: release at cycle t -> next owner's gnt rises at t+2+FLUSH_CYCLES (one IDLE cycle, FLUSH_CYCLES of flush, one GRANT cycle).
- Watchdog:
  - Counts OWNED cycles; resets on any cordic_vec_opvld, cordic_rot_opvld, or owner enable rising edge.
  - On reaching TIMEOUT: forced release with the same timing as a normal release, timeout_err=1 for one cycle, rr pointer advances.
- Simultaneous events: release and timeout in the same cycle -> treated as a normal release; timeout_err stays 0.
- No client ever receives a grant while cordic_nrst=0.
- Reset mid-operation: everything returns to reset values immediately; the client must re-request.

Test Plan:
- Single client: req[2]=1 -> cordic_nrst low 2 cycles, then gnt=4'b0100. Client vec (3,4) then rot (4,3) -> cli_vec_opvld[2] and cli_rot_opvld[2] pulse, other bits stay 0. rel[2] -> gnt=0 next cycle.
- Round-robin: req=4'b1111 held, each owner pulses rel after one rot -> grant order 0,1,2,3,0. Gap of exactly 2+FLUSH_CYCLES cycles between grants.
- Non-owner release: owner 1, rel[3] pulsed -> gnt unchanged. req[1] deasserted -> release.
- Watchdog: TIMEOUT=16, owner 0 holds with no enables -> forced release at cycle 16, timeout_err one-cycle pulse, next owner 1 granted.
- Mux isolation: owner 0 drives xin=0x1234; client 1 drives en=1, xin=0x7FFF -> cordic_vec_xin=0x1234. Idle -> all CORDIC enables 0.
- Async reset asserted mid-OWNED between clock edges -> gnt=0 and cordic_nrst=0 without waiting for a clock edge. After deassertion, arbitration restarts at client 0.
